// File: rtl/uart_pkg.sv
// Shared UART/CRC-8 constants, FSM state encoding and the bit-serial CRC step.
package uart_pkg;

    localparam int         CLKS_PER_BIT_DEF = 5208;
    localparam logic [7:0] CRC8_POLY        = 8'h07;
    localparam logic [7:0] CRC8_INIT        = 8'h00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4,
        CRCUPD = 3'd5,
        FLUSH  = 3'd6
    } state_t;

    // One MSB-first CRC-8 step: feedback is the outgoing MSB xor the new data bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/fifo_to_com_if.sv
// Bundle between the TX FIFO / frame controller (master) and fifo_to_com (slave).
interface fifo_to_com_if;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data_in;
    logic       fifo_re;
    logic       flush;
    logic       tx;
    logic       busy;
    logic       isFinish;
    logic [7:0] CRC;

    modport master (
        output enable, fifo_empty, fifo_data_in, flush,
        input  fifo_re, tx, busy, isFinish, CRC
    );

    modport slave (
        input  enable, fifo_empty, fifo_data_in, flush,
        output fifo_re, tx, busy, isFinish, CRC
    );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 serialiser: load captures a byte, 10*CLKS_PER_BIT cycles of line time, done on the last stop-bit cycle.
// No backpressure: load is only issued while idle; bit_end marks the final cycle of every bit.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       bit_end,
    output logic       done
);
    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shifter;
    logic          active;

    assign bit_end = active && (baud_cnt == BAUD_LAST);
    assign done    = bit_end && (bit_cnt == 4'd9);
    // Shifter refills with ones, so the line rests high between frames.
    assign tx      = shifter[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shifter  <= '1;
            active   <= 1'b0;
        end else if (load) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
            shifter  <= {1'b1, data, 1'b0};
            active   <= 1'b1;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                shifter  <= {1'b1, shifter[9:1]};
                if (bit_cnt == 4'd9) begin
                    bit_cnt <= 4'd0;
                    active  <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_to_com.sv
// TX FIFO -> 8N1 UART with running CRC-8; 1 + 10*CLKS_PER_BIT + 8 cycles per byte (FIFO_TO_COM_CRC_APPEND_EN sends CRC on flush).
// Pops only when enabled, idle and non-empty; a started byte always completes; flush is honoured only in IDLE.
module fifo_to_com
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fifo_to_com_if.slave  bus
);
    state_t     state;
    logic [7:0] shift_reg;
    logic [7:0] crc;
    logic [2:0] bit_idx;
    logic [2:0] crc_cnt;
    logic       fifo_re;
    logic       busy;
    logic       is_finish;

    logic       tx_load;
    logic [7:0] tx_data;
    logic       bit_end;
    logic       tx_done;

`ifdef FIFO_TO_COM_CRC_APPEND_EN
    logic       appending;
    assign tx_load = (state == POP) || (state == FLUSH);
    assign tx_data = (state == FLUSH) ? crc : bus.fifo_data_in;
`else
    assign tx_load = (state == POP);
    assign tx_data = bus.fifo_data_in;
`endif

    uart_transmitter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (tx_load),
        .data    (tx_data),
        .tx      (bus.tx),
        .bit_end (bit_end),
        .done    (tx_done)
    );

    assign bus.fifo_re  = fifo_re;
    assign bus.busy     = busy;
    assign bus.isFinish = is_finish;
    assign bus.CRC      = crc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fifo_re   <= 1'b0;
            busy      <= 1'b0;
            is_finish <= 1'b0;
            crc       <= CRC8_INIT;
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
            crc_cnt   <= 3'd0;
`ifdef FIFO_TO_COM_CRC_APPEND_EN
            appending <= 1'b0;
`endif
        end else begin
            is_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state <= FLUSH;
                        busy  <= 1'b1;
                    end else if (bus.enable && !bus.fifo_empty) begin
                        state   <= POP;
                        fifo_re <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                POP: begin
                    fifo_re   <= 1'b0;
                    shift_reg <= bus.fifo_data_in;
                    state     <= START;
                end
                START: begin
                    if (bit_end) state <= DATA;
                end
                DATA: begin
                    // bit_idx wraps 7->0 on the way into STOP
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (tx_done) begin
`ifdef FIFO_TO_COM_CRC_APPEND_EN
                        if (appending) begin
                            appending <= 1'b0;
                            crc       <= CRC8_INIT;
                            is_finish <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= CRCUPD;
                        end
`else
                        state <= CRCUPD;
`endif
                    end
                end
                CRCUPD: begin
                    crc     <= crc8_step(crc, shift_reg[3'd7 - crc_cnt]);
                    crc_cnt <= crc_cnt + 3'd1;
                    if (crc_cnt == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FLUSH: begin
`ifdef FIFO_TO_COM_CRC_APPEND_EN
                    appending <= 1'b1;
                    state     <= START;
`else
                    crc       <= CRC8_INIT;
                    is_finish <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
`endif
                end
                default: begin
                    state   <= IDLE;
                    fifo_re <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_to_com.sv
// Bench for fifo_to_com at CLKS_PER_BIT=4: job-timeline reference model, per-cycle compare, directed scenarios.
module tb_fifo_to_com;
    localparam int C         = 4;
    localparam int LINE_LEN  = 10 * C;
    localparam int BYTE_LEN  = LINE_LEN + 9;
`ifdef FIFO_TO_COM_CRC_APPEND_EN
    localparam bit APPEND    = 1'b1;
    localparam int FLUSH_LEN = 1 + LINE_LEN;
`else
    localparam bit APPEND    = 1'b0;
    localparam int FLUSH_LEN = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    fifo_to_com_if bus();

    fifo_to_com #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO: head is always presented; a pop advances it.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_data_in = mem[rd_ptr[5:0]];
    always @(posedge clk) if (bus.fifo_re === 1'b1 && wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {J_NONE, J_BYTE, J_FLUSH} job_e;
    job_e       job      = J_NONE;
    int         t        = 0;
    logic [7:0] job_byte = 8'h00;
    logic [7:0] crc_m    = 8'h00;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_re = 1'b0, e_fin = 1'b0, e_crc_ok = 1'b1;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Line level at job cycle tt: cycles 1..10*C carry start, 8 data bits LSB first, stop.
    function automatic logic line_at(input int tt, input logic [7:0] b);
        int k;
        if (tt < 1 || tt > LINE_LEN) return 1'b1;
        k = (tt - 1) / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            e_fin = 1'b0;
            if (reset) begin
                job   = J_NONE;
                crc_m = 8'h00;
            end else if (job == J_NONE) begin
                if (bus.flush) begin
                    job = J_FLUSH; t = 0; job_byte = crc_m;
                end else if (bus.enable && wr_ptr != rd_ptr) begin
                    job = J_BYTE; t = 0; job_byte = mem[rd_ptr[5:0]];
                end
            end else begin
                t++;
                if (job == J_BYTE && t == BYTE_LEN) begin
                    crc_m = crc8_byte(crc_m, job_byte);
                    job   = J_NONE;
                end else if (job == J_FLUSH && t == FLUSH_LEN) begin
                    crc_m = 8'h00;
                    e_fin = 1'b1;
                    job   = J_NONE;
                end
            end
            e_busy   = (job != J_NONE);
            e_re     = (job == J_BYTE) && (t == 0);
            e_tx     = (job == J_BYTE || (job == J_FLUSH && APPEND)) ? line_at(t, job_byte) : 1'b1;
            e_crc_ok = !(job == J_BYTE && t > LINE_LEN);
        end
    end

    // ---------------- per-cycle compare ----------------
    bit   chk_en = 1'b0;
    int   cyc    = 0;
    int   pop_cnt = 0;
    int   fin_cnt = 0;
    int   pop_cyc [$];
    logic tx_hist [0:4095];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check8("cyc_tx",      {7'd0, bus.tx},       {7'd0, e_tx});
                check8("cyc_busy",    {7'd0, bus.busy},     {7'd0, e_busy});
                check8("cyc_fifo_re", {7'd0, bus.fifo_re},  {7'd0, e_re});
                check8("cyc_finish",  {7'd0, bus.isFinish}, {7'd0, e_fin});
                if (e_crc_ok) check8("cyc_crc", bus.CRC, crc_m);
            end
            if (bus.fifo_re === 1'b1) begin
                pop_cnt++;
                pop_cyc.push_back(cyc);
            end
            if (bus.isFinish === 1'b1) fin_cnt++;
            if (cyc < 4096) tx_hist[cyc] = bus.tx;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int i;
        i = 0;
        while (bus.busy !== lvl && i < budget) begin
            step(1);
            i++;
        end
        check8(name, {7'd0, bus.busy}, {7'd0, lvl});
    endtask

    task automatic send_wait(input string name);
        wait_busy(1'b1, 10, {name, "_start"});
        wait_busy(1'b0, 2 * BYTE_LEN, {name, "_end"});
    endtask

    task automatic do_flush(input string name);
        int i;
        i = 0;
        bus.flush = 1'b1;
        while (bus.isFinish !== 1'b1 && i < 2 * BYTE_LEN) begin
            step(1);
            i++;
        end
        check8({name, "_finish"}, {7'd0, bus.isFinish}, 8'd1);
        bus.flush = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, f0;
        logic [9:0] bits55;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        bus.enable = 1'b0;
        bus.flush  = 1'b0;
        reset      = 1'b1;
        step(2);
        chk_en = 1'b1;
        check8("rst_tx",      {7'd0, bus.tx},       8'd1);
        check8("rst_busy",    {7'd0, bus.busy},     8'd0);
        check8("rst_fifo_re", {7'd0, bus.fifo_re},  8'd0);
        check8("rst_finish",  {7'd0, bus.isFinish}, 8'd0);
        check8("rst_crc",     bus.CRC,              8'h00);
        step(1);
        reset = 1'b0;
        step(1);

        // 1: single 0x55
        bus.enable = 1'b1;
        push(8'h55);
        send_wait("t1");
        check8("t1_crc", bus.CRC, 8'hAC);
        checkn("t1_pops", pop_cnt, 1);
        bits55 = 10'b1010101010;
        for (int k = 0; k < 10; k++)
            check8($sformatf("t1_line_bit%0d", k), {7'd0, tx_hist[pop_cyc[0] + 1 + k*C + 1]}, {7'd0, bits55[k]});
        do_flush("t1_flush");
        step(1);
        check8("t1_flush_crc", bus.CRC, 8'h00);

        // 2: 0x01 then 0x55 back to back
        p0 = pop_cnt;
        push(8'h01);
        push(8'h55);
        send_wait("t2_b1");
        check8("t2_crc1", bus.CRC, 8'h07);
        send_wait("t2_b2");
        check8("t2_crc2", bus.CRC, 8'hB9);
        checkn("t2_pops", pop_cnt - p0, 2);
        checkn("t2_spacing", pop_cyc[p0+1] - pop_cyc[p0], BYTE_LEN + 1);

        // 3: empty FIFO with enable high
        p0 = pop_cnt;
        step(200);
        checkn("t3_pops", pop_cnt - p0, 0);
        check8("t3_tx", {7'd0, bus.tx}, 8'd1);
        check8("t3_busy", {7'd0, bus.busy}, 8'd0);

        // 4: reset during the 4th data bit of 0xA3
        push(8'hA3);
        wait_busy(1'b1, 10, "t4_start");
        step(1 + C + 3*C + 1);
        reset = 1'b1;
        step(1);
        check8("t4_tx", {7'd0, bus.tx}, 8'd1);
        check8("t4_busy", {7'd0, bus.busy}, 8'd0);
        check8("t4_crc", bus.CRC, 8'h00);
        reset = 1'b0;
        push(8'h01);
        send_wait("t4_b");
        check8("t4_crc_after", bus.CRC, 8'h07);

        // 5: flush after 0x01
        f0 = fin_cnt;
        do_flush("t5");
        step(2);
        checkn("t5_finish_pulses", fin_cnt - f0, 1);
        check8("t5_crc", bus.CRC, 8'h00);

        // flush and pending data in the same IDLE cycle: flush first, then the byte
        push(8'h5A);
        do_flush("tb_both");
        send_wait("tb_both_b");
        check8("tb_both_crc", bus.CRC, 8'h81);

        // 6: enable dropped mid-byte with 3 bytes queued
        p0 = pop_cnt;
        push(8'h10);
        push(8'h20);
        push(8'h30);
        wait_busy(1'b1, 10, "t6_start");
        step(10);
        bus.enable = 1'b0;
        wait_busy(1'b0, 2 * BYTE_LEN, "t6_end");
        step(100);
        checkn("t6_pops_disabled", pop_cnt - p0, 1);
        bus.enable = 1'b1;
        send_wait("t6_b2");
        send_wait("t6_b3");
        checkn("t6_pops_total", pop_cnt - p0, 3);
        checkn("t6_fifo_drained", wr_ptr - rd_ptr, 0);
        step(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
